mips_result_drain: RTL and testbench
====================================

MIPS_RESULT_DRAIN -- requirements
Module: mips_result_drain

Interface
REQ-001 Parameter W, default 32, data word width in bits.
REQ-002 Parameter L, default 6, log2 of data-memory depth; N = 2**L words.
REQ-003 Parameter CW, default 16, width of the run-cycle count.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to run the core and then drain memory; sampled only in IDLE.
REQ-007 run_cycles  input  CW  number of cycles the core runs; sampled with start.
REQ-008 abort  input  1  synchronous cancel; overrides start.
REQ-009 core_run  output  1  high exactly while the core is allowed to execute; drives the core-side enable/reset gating.
REQ-010 mem_snapshot  input  N*W  flattened core data-memory image; word i sits at bits [i*W+W-1 : i*W].
REQ-011 out_valid  output  1  out_data/out_addr hold a valid word.
REQ-012 out_ready  input  1  consumer accepts the word on this edge when out_valid is also high.
REQ-013 out_data  output  W  drained memory word.
REQ-014 out_addr  output  L  word index of out_data.
REQ-015 out_last  output  1  high with out_valid when out_addr == N-1.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse after the final word transfers.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN, CAPTURE, DRAIN and DONE.
REQ-019 IDLE, start=1, abort=0: latch run_cycles into the down-counter; go to RUN if run_cycles != 0, else to CAPTURE.
REQ-020 RUN: core_run=1; decrement the counter each cycle; when it reaches 1, go to CAPTURE, so core_run is high for exactly run_cycles cycles.
REQ-021 CAPTURE: lasts exactly one cycle with core_run=0; load mem_snapshot into the internal snapshot register on the exit edge; clear the index to 0; go to DRAIN.
REQ-022 DRAIN: out_valid=1, out_addr=index, out_data=snapshot word[index].
REQ-023 On each edge with out_valid & out_ready, increment the index.
REQ-024 After the transfer at index N-1, go to DONE; the index does not wrap into a second pass.
REQ-025 While out_valid & !out_ready, out_data, out_addr and out_last SHALL hold stable.
REQ-026 out_valid SHALL not depend combinationally on out_ready.
REQ-027 DONE: done=1 for one cycle, then return to IDLE.
REQ-028 start is ignored when not in IDLE.
REQ-029 abort=1 in any state forces IDLE on the next edge: out_valid, core_run and done are 0 from that edge; the snapshot is not cleared.
REQ-030 The snapshot register SHALL change only on the CAPTURE exit edge; changes to mem_snapshot at other times have no effect on out_data.
REQ-031 Total latency from start to the first out_valid is run_cycles + 2 cycles (2 cycles when run_cycles = 0).

Reset
REQ-032 rst low SHALL asynchronously force: state IDLE, counter 0, index 0, snapshot 0, and all outputs 0 (core_run, out_valid, out_last, done, busy, out_data, out_addr).
REQ-033 Reset asserted mid-RUN or mid-DRAIN SHALL abandon the operation with no further output.
REQ-034 After rst is released, the first start is honoured on the first rising edge.

Structure
REQ-035 A shared package SHALL hold the state enumeration and the N = 2**L localparam helper.
REQ-036 Word selection is an inline N:1 mux; no sub-module is required.
REQ-037 The block is a single module of about 150-250 RTL lines.

Verification
REQ-038 W=32, L=2, run_cycles=5, out_ready=1, mem_snapshot words {0x11,0x22,0x33,0x44} -> core_run high 5 cycles; out_valid 2 cycles after the last core_run; addresses 0,1,2,3 with data 0x11..0x44 on 4 consecutive cycles; out_last on address 3; done the following cycle.
REQ-039 run_cycles=0 -> core_run never asserts; first out_valid 2 cycles after start.
REQ-040 out_ready toggled 1,0,0,1,... during DRAIN -> out_data/out_addr held stable while stalled; no word lost or duplicated; exactly N transfers.
REQ-041 mem_snapshot changed to 0xDEAD in every word during DRAIN -> drained data still equals the values captured at CAPTURE.
REQ-042 abort at the third RUN cycle -> core_run low next cycle, busy low, no out_valid; a new start afterwards runs normally.
REQ-043 rst driven low mid-DRAIN, asynchronous to clk -> all outputs 0 immediately; start=1 held during DRAIN is ignored.

Source files
------------

// File: rtl/mips_result_drain_pkg.sv
// Shared types and sizing helpers for the result-drain block.
package mips_result_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Word count of a memory with 2**l entries.
    function automatic int unsigned depth_words(input int unsigned l);
        return 32'(1) << l;
    endfunction

endpackage

// File: rtl/mips_result_drain_if.sv
// Valid/ready word stream carrying drained memory contents with address and last flag.
interface mips_result_drain_if #(
    parameter int unsigned W = 32,
    parameter int unsigned L = 6
);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [L-1:0] out_addr;
    logic         out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mips_result_drain.sv
// Runs the core for a programmed number of cycles, snapshots its data memory,
// then streams every word out over a valid/ready port.
module mips_result_drain
    import mips_result_drain_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned L  = 6,
    parameter int unsigned CW = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CW-1:0]                  run_cycles,
    input  logic                           abort,
    output logic                           core_run,
    input  logic [depth_words(L)*W-1:0]    mem_snapshot,
    output logic                           busy,
    output logic                           done,
    mips_result_drain_if.master            out_if
);

    localparam int unsigned N        = depth_words(L);
    localparam logic [L-1:0] LAST_IDX = L'(N - 1);

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic [L-1:0]  r_idx;
    logic [W-1:0]  r_snap [N];
    logic [W-1:0]  r_data;
    logic          r_valid;
    logic          r_last;
    logic          r_core_run;
    logic          r_busy;
    logic          r_done;

    logic [W-1:0]  w_words [N];
    logic [L-1:0]  w_idx_nxt;

    // Unflatten the live memory image into words.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            w_words[i] = mem_snapshot[i*W +: W];
        end
    end

    assign w_idx_nxt = r_idx + L'(1);

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_core_run <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                r_snap[i] <= '0;
            end
        end else if (abort) begin
            // Cancel from anywhere; captured snapshot is deliberately kept.
            r_state    <= ST_IDLE;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_core_run <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_cnt  <= run_cycles;
                        r_busy <= 1'b1;
                        if (run_cycles != '0) begin
                            r_state    <= ST_RUN;
                            r_core_run <= 1'b1;
                        end else begin
                            r_state <= ST_CAPTURE;
                        end
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state    <= ST_CAPTURE;
                        r_core_run <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    r_snap  <= w_words;
                    r_idx   <= '0;
                    r_data  <= w_words[0];
                    r_last  <= (LAST_IDX == '0);
                    r_valid <= 1'b1;
                    r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (out_if.out_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx  <= w_idx_nxt;
                            r_data <= r_snap[w_idx_nxt];
                            r_last <= (w_idx_nxt == LAST_IDX);
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_valid    <= 1'b0;
                    r_last     <= 1'b0;
                    r_core_run <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign core_run         = r_core_run;
    assign busy             = r_busy;
    assign done             = r_done;
    assign out_if.out_valid = r_valid;
    assign out_if.out_data  = r_data;
    assign out_if.out_addr  = r_idx;
    assign out_if.out_last  = r_last;

endmodule

// File: tb/tb_mips_result_drain.sv
// Scoreboard bench: jobs push the words they expect drained; a monitor pops on each transfer.
module tb_mips_result_drain;
    localparam int unsigned W  = 32;
    localparam int unsigned L  = 2;
    localparam int unsigned CW = 8;
    localparam int unsigned N  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] run_cycles = '0;
    logic [N*W-1:0] mem_snapshot = '0;
    logic          core_run;
    logic          busy;
    logic          done;
    logic          tb_ready = 1'b0;

    mips_result_drain_if #(.W(W), .L(L)) out_if ();
    assign out_if.out_ready = tb_ready;

    mips_result_drain #(.W(W), .L(L), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .run_cycles   (run_cycles),
        .abort        (abort),
        .core_run     (core_run),
        .mem_snapshot (mem_snapshot),
        .busy         (busy),
        .done         (done),
        .out_if       (out_if.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [L-1:0] addr;
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int rdy_k = 0;
    int tick = 0;
    int last_xfer_tick = -100;
    int xfers = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Consumer ready pattern, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       tb_ready = 1'b1;
            1:       tb_ready = (rdy_k % 3 == 0);
            2:       tb_ready = 1'($urandom_range(0, 1));
            default: tb_ready = 1'b0;
        endcase
        rdy_k++;
    end

    // Monitor: stability while stalled, and scoreboard pop on each accepted word.
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic [L-1:0] prev_addr = '0;
    logic         prev_last = 1'b0;
    exp_t         e;
    always @(negedge clk) begin
        tick++;
        if (rst) begin
            if (prev_valid && !prev_ready && out_if.out_valid) begin
                chk("stall_data", 64'(out_if.out_data), 64'(prev_data));
                chk("stall_addr", 64'(out_if.out_addr), 64'(prev_addr));
                chk("stall_last", 64'(out_if.out_last), 64'(prev_last));
            end
            if (out_if.out_valid && out_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer actual addr=%0d required none", out_if.out_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_addr", 64'(out_if.out_addr), 64'(e.addr));
                    chk("xfer_data", 64'(out_if.out_data), 64'(e.data));
                    chk("xfer_last", 64'(out_if.out_last), 64'(e.last));
                end
                xfers++;
                last_xfer_tick = tick;
            end
        end
        prev_valid = rst && out_if.out_valid;
        prev_ready = out_if.out_ready;
        prev_data  = out_if.out_data;
        prev_addr  = out_if.out_addr;
        prev_last  = out_if.out_last;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One full job: latency and core_run length from the request, then all N words and a done pulse.
    task automatic run_job(input int rc, input int mode, input bit scramble, input bit fixed);
        logic [W-1:0] words [N];
        int lat, crun;
        bit seen;
        step();
        ready_mode = mode;
        xfers = 0;
        for (int i = 0; i < int'(N); i++) begin
            words[i] = fixed ? W'(32'h11 * (i + 1)) : $urandom;
            mem_snapshot[i*W +: W] = words[i];
            exp_q.push_back('{addr: L'(i), data: words[i], last: (i == int'(N) - 1)});
        end
        run_cycles = CW'(rc);
        start = 1'b1;
        lat = 0;
        crun = 0;
        seen = 1'b0;
        for (int k = 0; k < rc + 12 && !seen; k++) begin
            step();
            start = 1'b0;
            lat++;
            if (core_run) crun++;
            if (out_if.out_valid) seen = 1'b1;
        end
        chk("first_valid_latency", 64'(lat), 64'(rc + 2));
        chk("core_run_cycles", 64'(crun), 64'(rc));
        if (scramble) begin
            for (int i = 0; i < int'(N); i++) mem_snapshot[i*W +: W] = 32'hDEAD;
        end
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            if (done) seen = 1'b1;
            else step();
        end
        chk("done_seen", 64'(seen), 64'(1));
        chk("xfer_count", 64'(xfers), 64'(N));
        chk("done_after_last", 64'(tick - last_xfer_tick), 64'(1));
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        step();
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("busy_after_done", 64'(busy), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_core_run"}, 64'(core_run), 64'(0));
        chk({tag, "_valid"}, 64'(out_if.out_valid), 64'(0));
        chk({tag, "_last"}, 64'(out_if.out_last), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_data"}, 64'(out_if.out_data), 64'(0));
        chk({tag, "_addr"}, 64'(out_if.out_addr), 64'(0));
    endtask

    initial begin
        int crun, nvalid;
        bit seen;
        #12;
        check_all_zero("reset");
        step();
        rst = 1'b1;

        run_job(5, 0, 1'b0, 1'b1);
        run_job(0, 0, 1'b0, 1'b0);
        run_job(3, 1, 1'b0, 1'b0);
        run_job(2, 0, 1'b1, 1'b0);
        run_job(4, 2, 1'b1, 1'b0);

        // Abort on the third core cycle: nothing may be drained.
        step();
        ready_mode = 0;
        for (int i = 0; i < int'(N); i++) mem_snapshot[i*W +: W] = $urandom;
        run_cycles = CW'(6);
        start = 1'b1;
        crun = 0;
        for (int k = 0; k < 20 && crun < 3; k++) begin
            step();
            start = 1'b0;
            if (core_run) crun++;
        end
        chk("abort_reached_run", 64'(crun), 64'(3));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_core_run", 64'(core_run), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_valid", 64'(out_if.out_valid), 64'(0));
        nvalid = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (out_if.out_valid || core_run) nvalid++;
        end
        chk("abort_stays_idle", 64'(nvalid), 64'(0));

        // Abort beats start in IDLE.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_over_start_busy", 64'(busy), 64'(0));
        chk("abort_over_start_run", 64'(core_run), 64'(0));

        run_job(1, 2, 1'b0, 1'b0);

        // Reset mid-DRAIN while stalled with start held high.
        step();
        ready_mode = 3;
        for (int i = 0; i < int'(N); i++) mem_snapshot[i*W +: W] = $urandom;
        run_cycles = CW'(1);
        start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (out_if.out_valid) seen = 1'b1;
        end
        chk("rst_test_in_drain", 64'(seen), 64'(1));
        start = 1'b1;
        for (int k = 0; k < 3; k++) step();
        chk("start_ignored_busy", 64'(busy), 64'(1));
        chk("start_ignored_addr", 64'(out_if.out_addr), 64'(0));
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        start = 1'b0;
        exp_q.delete();
        step();
        step();
        #2;
        rst = 1'b1;

        run_job(2, 0, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            run_job(int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
